// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: captures a word on load/ready and
// shifts it out one bit per shift_en edge, framed by frame and closed by done.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             out_bit;

  // Handshake: a word transfers on a rising edge where load=1 and ready=1;
  // load while ready=0 is ignored and data_in is not sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      frame <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= data_in;
            cnt   <= '0;
            state <= SHIFT;
            ready <= 1'b0;
            frame <= 1'b1;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              shreg <= '0;
              cnt   <= '0;
              state <= IDLE;
              ready <= 1'b1;
              frame <= 1'b0;
              done  <= 1'b1;
            end else begin
              if (MSB_FIRST) shreg <= {shreg[WIDTH-2:0], 1'b0};
              else           shreg <= {1'b0, shreg[WIDTH-1:1]};
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The output end of the register is gated by the frame flop so the link
  // idles low; both terms are registers.
  assign out_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign serial_out = frame & out_bit;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a word/index model plus literal bit sequences.
module tb_piso_shift_reg;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, load, shift_en;
  logic [W-1:0] data_in;
  logic         ready_m, so_m, frame_m, done_m;
  logic         ready_l, so_l, frame_l, done_l;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .shift_en(shift_en),
    .ready(ready_m), .serial_out(so_m), .frame(frame_m), .done(done_m));

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .shift_en(shift_en),
    .ready(ready_l), .serial_out(so_l), .frame(frame_l), .done(done_l));

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: the word in flight and how many of its bits have been consumed.
  logic         m_busy, m_done;
  logic [W-1:0] m_word;
  int           m_sent;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_word <= '0; m_sent <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (load) begin
          m_busy <= 1'b1; m_word <= data_in; m_sent <= 0;
        end
      end else if (shift_en) begin
        if (m_sent == W - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
        end else begin
          m_sent <= m_sent + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ready_m", ready_m, !m_busy);
    check("frame_m", frame_m, m_busy);
    check("done_m", done_m, m_done);
    check("serial_m", so_m, m_busy ? m_word[W-1-m_sent] : 1'b0);
    check("ready_l", ready_l, !m_busy);
    check("frame_l", frame_l, m_busy);
    check("done_l", done_l, m_done);
    check("serial_l", so_l, m_busy ? m_word[m_sent] : 1'b0);
  end

  // Reassemble each consumed bit; a full word is scored against exp_q.
  logic [W-1:0] cw_m, cw_l;
  int           cn;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cn = 0;
    end else if (frame_m && shift_en) begin
      cw_m = {cw_m[W-2:0], so_m};
      cw_l = {so_l, cw_l[W-1:1]};
      cn++;
      if (cn == W) begin
        cn = 0;
        if (exp_m.size() == 0 || exp_l.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_unexpected actual=%0h/%0h expected=none", cw_m, cw_l);
        end else begin
          check("word_m", cw_m, exp_m.pop_front());
          check("word_l", cw_l, exp_l.pop_front());
        end
      end
    end
  end

  task automatic load_word(input logic [W-1:0] w);
    load = 1'b1; data_in = w; shift_en = 1'b1;
    exp_m.push_back(w); exp_l.push_back(w);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame_end(input string name);
    int n = 0;
    while (frame_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, frame_m, 1'b0);
  endtask

  // seq_* hold the expected serial bits, first bit in [7].
  task automatic run_literal(input logic [W-1:0] w, input logic [W-1:0] seq_m,
                             input logic [W-1:0] seq_l);
    load_word(w);
    for (int k = 0; k < W; k++) begin
      check("lit_bit_m", so_m, seq_m[W-1-k]);
      check("lit_bit_l", so_l, seq_l[W-1-k]);
      check("lit_frame", frame_m, 1'b1);
      @(negedge clk);
    end
    check("lit_done", done_m, 1'b1);
    check("lit_ready", ready_m, 1'b1);
    check("lit_frame_end", frame_m, 1'b0);
    @(negedge clk);
    check("lit_done_single", done_m, 1'b0);
    check("lit_ready_after", ready_m, 1'b1);
    shift_en = 1'b0;
  endtask

  initial begin
    int len, gaps, n;
    int pat[4];
    pat = '{1, 0, 0, 1};
    reset = 1'b1; load = 1'b0; shift_en = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_m, 1'b1);
    check("rst_frame", frame_m, 1'b0);
    check("rst_done", done_m, 1'b0);
    check("rst_serial", so_m, 1'b0);
    reset = 1'b0;
    shift_en = 1'b1;
    repeat (2) @(negedge clk);

    run_literal(8'hA5, 8'hA5, 8'hA5);
    run_literal(8'h01, 8'h01, 8'h80);

    // Frame stretched by shift_en gaps.
    load_word(8'hC3);
    len = 0; gaps = 0; n = 0;
    while (frame_m && n < 100) begin
      len++;
      shift_en = (n < 4) ? pat[n][0] : 1'($urandom_range(0, 1));
      if (!shift_en) gaps++;
      n++;
      @(negedge clk);
    end
    check("gap_timeout", frame_m, 1'b0);
    check("gap_len", len, W + gaps);
    check("gap_done", done_m, 1'b1);
    shift_en = 1'b1;
    @(negedge clk);

    // Load during a frame is ignored.
    load_word(8'h5A);
    for (int k = 0; k < W; k++) begin
      check("busy_ready", ready_m, 1'b0);
      if (k == 3) begin
        load = 1'b1; data_in = 8'hFF;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_done", done_m, 1'b1);
    @(negedge clk);

    // Back-to-back frames with the second load in the done cycle.
    load_word(8'h81);
    n = 0;
    while (!done_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", done_m, 1'b1);
    check("b2b_gap_idle", frame_m, 1'b0);
    load_word(8'h7E);
    check("b2b_second_start", frame_m, 1'b1);
    wait_frame_end("b2b_timeout");
    @(negedge clk);

    // Asynchronous reset mid-frame, then a load on release.
    load = 1'b1; data_in = 8'hF0; shift_en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_serial_m", so_m, 1'b0);
    check("arst_serial_l", so_l, 1'b0);
    check("arst_frame", frame_m, 1'b0);
    check("arst_ready", ready_m, 1'b1);
    check("arst_done", done_m, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    load_word(8'h3C);
    wait_frame_end("arst_reload_timeout");
    check("arst_reload_done", done_m, 1'b1);
    shift_en = 1'b0;
    repeat (2) @(negedge clk);

    check("exp_m_drained", exp_m.size(), 0);
    check("exp_l_drained", exp_l.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
